// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers,
// with bounded bursts per grant and a watchdog on the transmitter's start handshake.
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int MAX_BURST     = 4,
   parameter int START_TIMEOUT = 12000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          tx_enable,
   output logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_busy,
   output logic                          tx_timeout,
   output logic                          arb_busy
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int TW = $clog2(START_TIMEOUT + 1);

   localparam logic [PW-1:0]      LAST_REQ   = PW'(NUM_REQ - 1);
   localparam logic [BW-1:0]      LAST_BURST = BW'(MAX_BURST - 1);
   localparam logic [TW-1:0]      LAST_TICK  = TW'(START_TIMEOUT - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_SEND
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [PW-1:0]         r_rr_ptr;
   logic [PW-1:0]         r_owner;
   logic [BW-1:0]         r_burst_cnt;
   logic [TW-1:0]         r_timer;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic [NUM_REQ-1:0]    r_grant;
   logic [NUM_REQ-1:0]    r_req_ack;
   logic                  r_tx_timeout;

   logic                  w_found;
   logic [PW-1:0]         w_sel;
   logic [PW-1:0]         w_scan_idx;
   logic                  w_capture;
   logic [PW-1:0]         w_cap_idx;
   logic [DATA_WIDTH-1:0] w_cap_data;
   logic                  w_release;
   logic                  w_timeout;
   logic [PW-1:0]         w_next_ptr;
   logic                  w_burst_more;

   // First requester at or after the round-robin pointer, wrapping modulo NUM_REQ.
   always_comb begin
      w_found    = 1'b0;
      w_sel      = '0;
      w_scan_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_scan_idx = PW'((32'(r_rr_ptr) + i) % NUM_REQ);
         if (!w_found && req[w_scan_idx]) begin
            w_found = 1'b1;
            w_sel   = w_scan_idx;
         end
      end
   end

   assign w_next_ptr   = (r_owner == LAST_REQ) ? '0 : r_owner + PW'(1);
   assign w_burst_more = (r_burst_cnt != LAST_BURST);
   assign w_cap_data   = req_data[w_cap_idx*DATA_WIDTH +: DATA_WIDTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_cap_idx    = w_sel;
      w_release    = 1'b0;
      w_timeout    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!tx_busy && w_found) begin
               w_capture    = 1'b1;
               w_cap_idx    = w_sel;
               w_state_next = S_START;
            end
         end
         S_START: begin
            // A busy response on the final watchdog tick still counts as a start.
            if (tx_busy) begin
               w_state_next = S_SEND;
            end else if (r_timer == LAST_TICK) begin
               w_timeout    = 1'b1;
               w_release    = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         S_SEND: begin
            if (!tx_busy) begin
               if (req[r_owner] && w_burst_more) begin
                  w_capture    = 1'b1;
                  w_cap_idx    = r_owner;
                  w_state_next = S_START;
               end else begin
                  w_release    = 1'b1;
                  w_state_next = S_IDLE;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_ptr     <= '0;
         r_owner      <= '0;
         r_burst_cnt  <= '0;
         r_timer      <= '0;
         r_tx_data    <= '0;
         r_grant      <= '0;
         r_req_ack    <= '0;
         r_tx_timeout <= 1'b0;
      end else begin
         r_req_ack    <= '0;
         r_tx_timeout <= w_timeout;
         if (w_capture) begin
            r_tx_data   <= w_cap_data;
            r_owner     <= w_cap_idx;
            r_grant     <= ONE_HOT0 << w_cap_idx;
            r_req_ack   <= ONE_HOT0 << w_cap_idx;
            r_timer     <= '0;
            r_burst_cnt <= (r_state == S_IDLE) ? '0 : r_burst_cnt + BW'(1);
         end else if (r_state == S_START) begin
            r_timer <= r_timer + TW'(1);
         end
         if (w_release) begin
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
         end
      end
   end

   assign req_ack    = r_req_ack;
   assign grant      = r_grant;
   assign tx_enable  = (r_state == S_START);
   assign tx_data    = r_tx_data;
   assign tx_timeout = r_tx_timeout;
   assign arb_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-fed requesters, transmitter models and a
// capture scoreboard; instance b runs with single-byte grants for the rotation check.
module tb_uart_tx_arbiter;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;

   logic [3:0]  req_a;
   logic [31:0] req_data_a;
   logic [3:0]  req_ack_a, grant_a;
   logic        tx_enable_a, tx_busy_a, tx_timeout_a, arb_busy_a;
   logic [7:0]  tx_data_a;

   logic [3:0]  req_b;
   logic [31:0] req_data_b;
   logic [3:0]  req_ack_b, grant_b;
   logic        tx_enable_b, tx_busy_b, tx_timeout_b, arb_busy_b;
   logic [7:0]  tx_data_b;

   logic [7:0]  src [4][8];
   int          head [4];
   int          tail [4];
   exp_t        sb_a[$];
   exp_t        sb_b[$];

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_ack_a = 0;
   int          n_ack_b = 0;
   int          n_to_a = 0;
   int          en_run = 0;
   int          en_len = 0;

   logic        force_busy, m_dead;
   logic        ma_busy, mb_busy;
   logic [1:0]  ma_cnt, mb_cnt;
   logic [4:0]  ma_hold, mb_hold;

   always #5 clk = ~clk;

   uart_tx_arbiter dut (
      .clk(clk), .reset(reset), .req(req_a), .req_data(req_data_a),
      .req_ack(req_ack_a), .grant(grant_a), .tx_enable(tx_enable_a),
      .tx_data(tx_data_a), .tx_busy(tx_busy_a), .tx_timeout(tx_timeout_a),
      .arb_busy(arb_busy_a)
   );

   uart_tx_arbiter #(.MAX_BURST(1)) dut_b (
      .clk(clk), .reset(reset), .req(req_b), .req_data(req_data_b),
      .req_ack(req_ack_b), .grant(grant_b), .tx_enable(tx_enable_b),
      .tx_data(tx_data_b), .tx_busy(tx_busy_b), .tx_timeout(tx_timeout_b),
      .arb_busy(arb_busy_b)
   );

   assign req_data_b = 32'hB3B2B1B0;

   always_comb begin
      req_a      = '0;
      req_data_a = '0;
      for (int i = 0; i < 4; i++) begin
         if (head[i] != tail[i]) begin
            req_a[i]           = 1'b1;
            req_data_a[i*8 +: 8] = src[i][head[i][2:0]];
         end
      end
   end

   // Transmitter model: busy rises 3 cycles after enable, holds 20 cycles.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ma_busy <= 1'b0; ma_cnt <= '0; ma_hold <= '0;
      end else if (ma_busy) begin
         if (ma_hold == 5'd19) begin ma_busy <= 1'b0; ma_hold <= '0; end
         else ma_hold <= ma_hold + 5'd1;
      end else if (tx_enable_a && !m_dead) begin
         if (ma_cnt == 2'd2) begin ma_busy <= 1'b1; ma_cnt <= '0; end
         else ma_cnt <= ma_cnt + 2'd1;
      end else begin
         ma_cnt <= '0;
      end
   end
   assign tx_busy_a = ma_busy | force_busy;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mb_busy <= 1'b0; mb_cnt <= '0; mb_hold <= '0;
      end else if (mb_busy) begin
         if (mb_hold == 5'd19) begin mb_busy <= 1'b0; mb_hold <= '0; end
         else mb_hold <= mb_hold + 5'd1;
      end else if (tx_enable_b) begin
         if (mb_cnt == 2'd2) begin mb_busy <= 1'b1; mb_cnt <= '0; end
         else mb_cnt <= mb_cnt + 2'd1;
      end else begin
         mb_cnt <= '0;
      end
   end
   assign tx_busy_b = mb_busy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int r, input logic [7:0] d);
      exp_t e;
      src[r][tail[r][2:0]] = d;
      tail[r]++;
      e.idx  = r;
      e.data = d;
      sb_a.push_back(e);
   endtask

   task automatic wait_ack_a(input int n, input string tag);
      int k = 0;
      while (n_ack_a < n && k < 20000) begin @(negedge clk); k++; end
      check(tag, n_ack_a, n);
   endtask

   task automatic wait_idle_a(input string tag);
      int k = 0;
      while (arb_busy_a !== 1'b0 && k < 20000) begin @(negedge clk); k++; end
      check(tag, {31'd0, arb_busy_a}, 32'd0);
   endtask

   task automatic wait_busy_a(input logic v, input string tag);
      int k = 0;
      while (tx_busy_a !== v && k < 200) begin @(negedge clk); k++; end
      check(tag, {31'd0, tx_busy_a}, {31'd0, v});
   endtask

   // Scoreboard on the capture pulse; the acked requester advances its queue.
   always @(negedge clk) begin
      if (tx_enable_a) en_run++;
      else if (en_run != 0) begin en_len = en_run; en_run = 0; end
      if (tx_timeout_a) n_to_a++;
      if (req_ack_a != 4'd0) begin
         n_ack_a++;
         check("a_sb_nonempty", sb_a.size(), (sb_a.size() == 0) ? 32'd1 : sb_a.size());
         if (sb_a.size() != 0) begin
            exp_t e;
            e = sb_a.pop_front();
            check("a_req_ack", {28'd0, req_ack_a}, 32'd1 << e.idx);
            check("a_grant", {28'd0, grant_a}, 32'd1 << e.idx);
            check("a_tx_data", {24'd0, tx_data_a}, {24'd0, e.data});
         end
         for (int i = 0; i < 4; i++)
            if (req_ack_a[i] && head[i] != tail[i]) head[i]++;
      end
   end

   always @(negedge clk) begin
      if (req_ack_b != 4'd0) begin
         n_ack_b++;
         check("b_sb_nonempty", sb_b.size(), (sb_b.size() == 0) ? 32'd1 : sb_b.size());
         if (sb_b.size() != 0) begin
            exp_t e;
            e = sb_b.pop_front();
            check("b_req_ack", {28'd0, req_ack_b}, 32'd1 << e.idx);
            check("b_grant", {28'd0, grant_b}, 32'd1 << e.idx);
            check("b_tx_data", {24'd0, tx_data_b}, {24'd0, e.data});
         end
      end
   end

   initial begin
      exp_t e;
      int   k;
      reset      = 1'b1;
      force_busy = 1'b0;
      m_dead     = 1'b0;
      req_b      = '0;
      for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; end
      repeat (3) @(negedge clk);
      check("rst_req_ack", {28'd0, req_ack_a}, 32'd0);
      check("rst_grant", {28'd0, grant_a}, 32'd0);
      check("rst_tx_enable", {31'd0, tx_enable_a}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data_a}, 32'd0);
      check("rst_tx_timeout", {31'd0, tx_timeout_a}, 32'd0);
      check("rst_arb_busy", {31'd0, arb_busy_a}, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Single byte
      push(0, 8'hA5);
      wait_ack_a(1, "t1_ack");
      wait_idle_a("t1_idle");
      check("t1_enable_len", en_len, 32'd4);
      check("t1_grant_clear", {28'd0, grant_a}, 32'd0);
      check("t1_rr_ptr", {30'd0, dut.r_rr_ptr}, 32'd1);

      // Burst limit: six bytes from requester 2 become a 4-byte and a 2-byte grant
      for (int d = 8'h10; d <= 8'h15; d++) push(2, 8'(d));
      wait_busy_a(1'b1, "t2_busy_rise");
      wait_busy_a(1'b0, "t2_busy_fall");
      @(negedge clk);
      check("t2_b2b_enable", {31'd0, tx_enable_a}, 32'd1);
      check("t2_b2b_ack", {28'd0, req_ack_a}, 32'h4);
      wait_ack_a(5, "t2_four_acks");
      k = 0;
      while (grant_a !== 4'd0 && k < 200) begin @(negedge clk); k++; end
      check("t2_grant_clear", {28'd0, grant_a}, 32'd0);
      check("t2_idle_gap", {31'd0, arb_busy_a}, 32'd0);
      check("t2_acks_at_gap", n_ack_a, 32'd5);
      wait_ack_a(7, "t2_second_grant");
      wait_idle_a("t2_idle");

      // Round-robin with single-byte grants on instance b
      for (int i = 0; i < 5; i++) begin
         e.idx  = i % 4;
         e.data = 8'hB0 + 8'(i % 4);
         sb_b.push_back(e);
      end
      req_b = 4'hF;
      k = 0;
      while (n_ack_b < 5 && k < 2000) begin @(negedge clk); k++; end
      req_b = 4'h0;
      check("t3_rr_acks", n_ack_b, 32'd5);
      k = 0;
      while (arb_busy_b !== 1'b0 && k < 200) begin @(negedge clk); k++; end
      check("t3_idle", {31'd0, arb_busy_b}, 32'd0);

      // External busy holds off the capture
      force_busy = 1'b1;
      push(1, 8'h3C);
      repeat (5) @(negedge clk);
      check("t4_no_ack", {28'd0, req_ack_a}, 32'd0);
      check("t4_no_enable", {31'd0, tx_enable_a}, 32'd0);
      check("t4_idle", {31'd0, arb_busy_a}, 32'd0);
      check("t4_ack_count", n_ack_a, 32'd7);
      force_busy = 1'b0;
      @(negedge clk);
      check("t4_ack_next_edge", {28'd0, req_ack_a}, 32'h2);
      wait_idle_a("t4_done");

      // Watchdog: requester 3 times out, then requester 0 is next in order
      m_dead = 1'b1;
      push(3, 8'hE1);
      push(0, 8'h0F);
      push(3, 8'hE2);
      k = 0;
      while (tx_timeout_a !== 1'b1 && k < 13000) begin @(negedge clk); k++; end
      check("t5_timeout_pulse", {31'd0, tx_timeout_a}, 32'd1);
      check("t5_grant_clear", {28'd0, grant_a}, 32'd0);
      m_dead = 1'b0;
      @(negedge clk);
      check("t5_start_len", en_len, 32'd12000);
      check("t5_timeout_count", n_to_a, 32'd1);
      wait_ack_a(11, "t5_acks");
      wait_idle_a("t5_idle");

      // Asynchronous reset while in SEND
      push(1, 8'h51);
      push(1, 8'h52);
      push(1, 8'h53);
      wait_ack_a(12, "t6_first_ack");
      wait_busy_a(1'b1, "t6_busy");
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_grant", {28'd0, grant_a}, 32'd0);
      check("t6_rst_enable", {31'd0, tx_enable_a}, 32'd0);
      check("t6_rst_ack", {28'd0, req_ack_a}, 32'd0);
      check("t6_rst_arb_busy", {31'd0, arb_busy_a}, 32'd0);
      head[1] = tail[1];
      sb_a.delete();
      @(negedge clk);
      reset = 1'b0;
      check("t6_rr_ptr", {30'd0, dut.r_rr_ptr}, 32'd0);
      push(2, 8'h6B);
      wait_ack_a(13, "t6_regrant");
      wait_idle_a("t6_idle");

      check("end_sb_a_empty", sb_a.size(), 32'd0);
      check("end_sb_b_empty", sb_b.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
